// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared encodings for the ALU issue controller.
//   - alu_ctrl_e    : 3-bit ALUControl codes understood by ALU32Bit
//   - alu_op_e      : 2-bit ALUOp request class
//   - FUNCT_*       : function-field values decoded for R-type/extended ops
//   - issue_state_e : issue FSM states
package alu_issue_pkg;

   typedef enum logic [2:0] {
      ALUC_AND  = 3'd0,
      ALUC_OR   = 3'd1,
      ALUC_ADD  = 3'd2,
      ALUC_ANDN = 3'd4,
      ALUC_ORN  = 3'd5,
      ALUC_SUB  = 3'd6,
      ALUC_SLT  = 3'd7
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_RTYPE = 2'b10,
      ALUOP_EXT   = 2'b11
   } alu_op_e;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } issue_state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request/response handshake bundle of the ALU issue controller.
//   Request  : ReqValid/ReqReady, ReqALUOp, ReqFunct, ReqA, ReqB, ReqTag
//   Response : RspValid/RspReady, RspResult, RspZero, RspIllegal, RspTag
//   master = requester side, slave = alu_issue_ctrl side.
interface alu_issue_ctrl_if #(
   parameter int unsigned TAG_W = 4
);
   logic             ReqValid;
   logic             ReqReady;
   logic [1:0]       ReqALUOp;
   logic [5:0]       ReqFunct;
   logic [31:0]      ReqA;
   logic [31:0]      ReqB;
   logic [TAG_W-1:0] ReqTag;

   logic             RspValid;
   logic             RspReady;
   logic [31:0]      RspResult;
   logic             RspZero;
   logic             RspIllegal;
   logic [TAG_W-1:0] RspTag;

   modport master (
      output ReqValid, ReqALUOp, ReqFunct, ReqA, ReqB, ReqTag, RspReady,
      input  ReqReady, RspValid, RspResult, RspZero, RspIllegal, RspTag
   );

   modport slave (
      input  ReqValid, ReqALUOp, ReqFunct, ReqA, ReqB, ReqTag, RspReady,
      output ReqReady, RspValid, RspResult, RspZero, RspIllegal, RspTag
   );
endinterface

// File: rtl/alu_funct_decode.sv
// alu_funct_decode: combinational ALUOp/Funct -> ALUControl decoder.
//   ALUOp      in  2  request class
//   Funct      in  6  function field
//   ALUControl out 3  ALU operation code (ADD when illegal)
//   Illegal    out 1  combination is not decodable
module alu_funct_decode
   import alu_issue_pkg::*;
(
   input  logic [1:0] ALUOp,
   input  logic [5:0] Funct,
   output logic [2:0] ALUControl,
   output logic       Illegal
);

   always_comb begin
      ALUControl = ALUC_ADD;
      Illegal    = 1'b0;
      case (ALUOp)
         ALUOP_ADD: ALUControl = ALUC_ADD;
         ALUOP_SUB: ALUControl = ALUC_SUB;
         ALUOP_RTYPE: begin
            case (Funct)
               FUNCT_ADD: ALUControl = ALUC_ADD;
               FUNCT_SUB: ALUControl = ALUC_SUB;
               FUNCT_AND: ALUControl = ALUC_AND;
               FUNCT_OR:  ALUControl = ALUC_OR;
               FUNCT_SLT: ALUControl = ALUC_SLT;
               default:   Illegal    = 1'b1;
            endcase
         end
         ALUOP_EXT: begin
            case (Funct)
               FUNCT_AND: ALUControl = ALUC_ANDN;
               FUNCT_OR:  ALUControl = ALUC_ORN;
               default:   Illegal    = 1'b1;
            endcase
         end
         default: Illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: initiator side of the ALU32Bit interface.
//   Clk, Rst_n         clock (rising edge), async active-low reset
//   bus (slave)        request/response handshake bundle
//   ALUControl, A, B   registered operation/operands driven to the ALU
//   ALUResult, Zero    combinational ALU outputs, captured in EXEC
//   OpCount            saturating count of completed responses
//   IllegalCount       saturating count of completed illegal responses
// One op every two cycles at best: IDLE/RESP accept -> EXEC -> RESP.
module alu_issue_ctrl
   import alu_issue_pkg::*;
#(
   parameter int unsigned TAG_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic              Clk,
   input  logic              Rst_n,
   alu_issue_ctrl_if.slave   bus,
   output logic [2:0]        ALUControl,
   output logic [31:0]       A,
   output logic [31:0]       B,
   input  logic [31:0]       ALUResult,
   input  logic              Zero,
   output logic [CNT_W-1:0]  OpCount,
   output logic [CNT_W-1:0]  IllegalCount
);

   issue_state_e     state, state_nxt;
   logic             req_ready, rsp_valid;
   logic             accept, rsp_hs;
   logic [2:0]       dec_ctrl;
   logic             dec_illegal;
   logic [TAG_W-1:0] tag_q;
   logic             illegal_q;
   logic [31:0]      rsp_result;
   logic             rsp_zero;
   logic             rsp_illegal;
   logic [TAG_W-1:0] rsp_tag;

   alu_funct_decode u_decode (
      .ALUOp      (bus.ReqALUOp),
      .Funct      (bus.ReqFunct),
      .ALUControl (dec_ctrl),
      .Illegal    (dec_illegal)
   );

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // In RESP the request side is ready exactly when the response is being
   // consumed, so a waiting request can slip straight into EXEC.
   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (bus.ReqValid) state_nxt = ST_EXEC;
         end
         ST_EXEC: state_nxt = ST_RESP;
         ST_RESP: begin
            rsp_valid = 1'b1;
            req_ready = bus.RspReady;
            if (bus.RspReady) state_nxt = bus.ReqValid ? ST_EXEC : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign accept = bus.ReqValid & req_ready;
   assign rsp_hs = rsp_valid & bus.RspReady;

   // Operands and decoded control hold their last values between requests.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         A          <= '0;
         B          <= '0;
         ALUControl <= '0;
         tag_q      <= '0;
         illegal_q  <= 1'b0;
      end else if (accept) begin
         A          <= bus.ReqA;
         B          <= bus.ReqB;
         ALUControl <= dec_ctrl;
         tag_q      <= bus.ReqTag;
         illegal_q  <= dec_illegal;
      end
   end

   // Illegal ops still pass through EXEC so responses stay in tag order;
   // their ALU output is masked off here.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rsp_result  <= '0;
         rsp_zero    <= 1'b0;
         rsp_illegal <= 1'b0;
         rsp_tag     <= '0;
      end else if (state == ST_EXEC) begin
         rsp_result  <= illegal_q ? '0 : ALUResult;
         rsp_zero    <= illegal_q ? 1'b0 : Zero;
         rsp_illegal <= illegal_q;
         rsp_tag     <= tag_q;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         OpCount      <= '0;
         IllegalCount <= '0;
      end else if (rsp_hs) begin
         if (OpCount != '1) OpCount <= OpCount + 1'b1;
         if (rsp_illegal && (IllegalCount != '1)) IllegalCount <= IllegalCount + 1'b1;
      end
   end

   assign bus.ReqReady   = req_ready;
   assign bus.RspValid   = rsp_valid;
   assign bus.RspResult  = rsp_result;
   assign bus.RspZero    = rsp_zero;
   assign bus.RspIllegal = rsp_illegal;
   assign bus.RspTag     = rsp_tag;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl (CNT_W=4 build so
// counter saturation is reachable). A behavioural ALU32Bit sits on the ALU side.
module tb_alu_issue_ctrl;
   import alu_issue_pkg::*;

   localparam int unsigned TAG_W   = 4;
   localparam int unsigned CNT_W   = 4;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic             Clk = 1'b0;
   logic             Rst_n = 1'b0;
   logic [2:0]       ALUControl;
   logic [31:0]      A, B, ALUResult;
   logic             Zero;
   logic [CNT_W-1:0] OpCount, IllegalCount;

   alu_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

   alu_issue_ctrl #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .bus          (bus),
      .ALUControl   (ALUControl),
      .A            (A),
      .B            (B),
      .ALUResult    (ALUResult),
      .Zero         (Zero),
      .OpCount      (OpCount),
      .IllegalCount (IllegalCount)
   );

   always #5 Clk = ~Clk;

   function automatic logic [31:0] alu_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a + b;
         3'd4:    return a & ~b;
         3'd5:    return a | ~b;
         3'd6:    return a - b;
         3'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return '0;
      endcase
   endfunction

   always_comb ALUResult = alu_fn(ALUControl, A, B);
   assign Zero = (ALUResult == '0);

   typedef struct {
      logic [31:0]      result;
      logic             zero;
      logic             illegal;
      logic [TAG_W-1:0] tag;
   } rsp_t;

   rsp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int unsigned exp_ops = 0;
   int unsigned exp_ill = 0;

   function automatic rsp_t model(input logic [1:0] op, input logic [5:0] f,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [TAG_W-1:0] tag);
      rsp_t r;
      int   code;
      code = -1;
      if (op == 2'b00) code = 2;
      else if (op == 2'b01) code = 6;
      else if (op == 2'b10) begin
         if (f == 6'h20) code = 2;
         else if (f == 6'h22) code = 6;
         else if (f == 6'h24) code = 0;
         else if (f == 6'h25) code = 1;
         else if (f == 6'h2A) code = 7;
      end else begin
         if (f == 6'h24) code = 4;
         else if (f == 6'h25) code = 5;
      end
      r.tag = tag;
      if (code < 0) begin
         r.result = '0; r.zero = 1'b0; r.illegal = 1'b1;
      end else begin
         r.result  = alu_fn(code[2:0], a, b);
         r.zero    = (r.result == '0);
         r.illegal = 1'b0;
      end
      return r;
   endfunction

   function automatic int unsigned sat_inc(input int unsigned v);
      return (v < CNT_MAX) ? v + 1 : v;
   endfunction

   // Drives one request and waits (bounded) for acceptance; pushes the
   // expected response on acceptance. Returns at accept edge + 1.
   task automatic drive_req(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [TAG_W-1:0] tag, output bit ok);
      bit rdy;
      bus.ReqValid = 1'b1;
      bus.ReqALUOp = op;
      bus.ReqFunct = f;
      bus.ReqA     = a;
      bus.ReqB     = b;
      bus.ReqTag   = tag;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge Clk);
         rdy = bus.ReqReady;
         @(posedge Clk); #1;
         if (rdy) begin
            ok = 1'b1;
            sb.push_back(model(op, f, a, b, tag));
         end
      end
      bus.ReqValid = 1'b0;
   endtask

   // Waits (bounded) for a response, samples it, completes the handshake and
   // pops the matching expectation. Comparisons are left to the caller.
   task automatic recv_rsp(output bit got, output rsp_t r, output rsp_t e);
      got = 1'b0;
      r.result = '0; r.zero = 1'b0; r.illegal = 1'b0; r.tag = '0;
      e = r;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge Clk);
         if (bus.RspValid === 1'b1) begin
            got          = 1'b1;
            r.result     = bus.RspResult;
            r.zero       = bus.RspZero;
            r.illegal    = bus.RspIllegal;
            r.tag        = bus.RspTag;
            bus.RspReady = 1'b1;
         end
         @(posedge Clk); #1;
      end
      bus.RspReady = 1'b0;
      if (got && sb.size() > 0) begin
         e = sb.pop_front();
         exp_ops = sat_inc(exp_ops);
         if (e.illegal) exp_ill = sat_inc(exp_ill);
      end
   endtask

   task automatic test_reset();
      bus.ReqValid = 1'b0; bus.RspReady = 1'b0; bus.ReqALUOp = '0; bus.ReqFunct = '0;
      bus.ReqA = '0; bus.ReqB = '0; bus.ReqTag = '0;
      Rst_n = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      checks++; if (bus.RspValid !== 1'b0) begin errors++; $display("FAIL reset_rspvalid got %b exp 0", bus.RspValid); end
      checks++; if (bus.ReqReady !== 1'b1) begin errors++; $display("FAIL reset_reqready got %b exp 1", bus.ReqReady); end
      checks++; if (OpCount !== '0 || IllegalCount !== '0) begin errors++; $display("FAIL reset_counters got %0d/%0d exp 0/0", OpCount, IllegalCount); end
      checks++; if (ALUControl !== '0 || A !== '0 || B !== '0) begin errors++; $display("FAIL reset_alu_regs got %0d %h %h exp 0", ALUControl, A, B); end
      checks++; if (bus.RspResult !== '0 || bus.RspTag !== '0 || bus.RspZero !== 1'b0 || bus.RspIllegal !== 1'b0) begin
         errors++; $display("FAIL reset_rsp_regs got %h %h %b %b exp 0", bus.RspResult, bus.RspTag, bus.RspZero, bus.RspIllegal); end
      Rst_n = 1'b1;
      @(posedge Clk); #1;
   endtask

   task automatic test_basic();
      bit ok, got;
      rsp_t r, e;
      drive_req(2'b10, 6'h20, 32'd5, 32'd7, 4'd3, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_accept timeout"); end
      checks++; if (ALUControl !== 3'd2) begin errors++; $display("FAIL basic_aluctl got %0d exp 2", ALUControl); end
      checks++; if (A !== 32'd5 || B !== 32'd7) begin errors++; $display("FAIL basic_operands got %h %h exp 5 7", A, B); end
      checks++; if (bus.RspValid !== 1'b0) begin errors++; $display("FAIL basic_rspvalid_early got %b exp 0", bus.RspValid); end
      @(posedge Clk); #1;
      checks++; if (bus.RspValid !== 1'b1) begin errors++; $display("FAIL basic_rspvalid_latency got %b exp 1", bus.RspValid); end
      recv_rsp(got, r, e);
      checks++; if (!got) begin errors++; $display("FAIL basic_rsp timeout"); end
      checks++; if (r.result !== 32'd12 || r.result !== e.result) begin errors++; $display("FAIL basic_result got %h exp %h", r.result, 32'd12); end
      checks++; if (r.zero !== 1'b0 || r.illegal !== 1'b0) begin errors++; $display("FAIL basic_flags got z%b i%b exp z0 i0", r.zero, r.illegal); end
      checks++; if (r.tag !== 4'd3) begin errors++; $display("FAIL basic_tag got %0d exp 3", r.tag); end
      checks++; if (OpCount !== exp_ops[CNT_W-1:0]) begin errors++; $display("FAIL basic_opcount got %0d exp %0d", OpCount, exp_ops); end
   endtask

   task automatic test_ops();
      logic [1:0]  t_op [9] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
      logic [5:0]  t_fn [9] = '{6'h00, 6'h2A, 6'h24, 6'h00, 6'h24, 6'h25, 6'h22, 6'h25, 6'h2A};
      logic [31:0] t_a  [9] = '{32'h1234, 32'd3, 32'hFF, 32'hFFFFFFFF, 32'hF0F0, 32'hF0, 32'd10, 32'h0, 32'hFFFFFFFF};
      logic [31:0] t_b  [9] = '{32'h1234, 32'd9, 32'h0F, 32'd1, 32'hFF00, 32'h0F, 32'd3, 32'hFFFFFFFE, 32'd1};
      logic [31:0] t_res[9] = '{32'h0, 32'd1, 32'hF0, 32'h0, 32'hF000, 32'hFF, 32'd7, 32'd1, 32'd1};
      logic        t_z  [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      bit ok, got;
      rsp_t r, e;
      logic [TAG_W-1:0] tg;
      for (int i = 0; i < 9; i++) begin
         tg = TAG_W'(i + 1);
         drive_req(t_op[i], t_fn[i], t_a[i], t_b[i], tg, ok);
         recv_rsp(got, r, e);
         checks++; if (!ok || !got) begin errors++; $display("FAIL ops_handshake[%0d] acc %b rsp %b exp 1 1", i, ok, got); end
         checks++; if (r.result !== t_res[i]) begin errors++; $display("FAIL ops_result[%0d] got %h exp %h", i, r.result, t_res[i]); end
         checks++; if (r.zero !== t_z[i] || r.illegal !== 1'b0) begin errors++; $display("FAIL ops_flags[%0d] got z%b i%b exp z%b i0", i, r.zero, r.illegal, t_z[i]); end
         checks++; if (r.tag !== tg) begin errors++; $display("FAIL ops_tag[%0d] got %0d exp %0d", i, r.tag, tg); end
         checks++; if (OpCount !== exp_ops[CNT_W-1:0]) begin errors++; $display("FAIL ops_opcount[%0d] got %0d exp %0d", i, OpCount, exp_ops); end
      end
   endtask

   task automatic test_illegal();
      bit ok, got;
      rsp_t r, e;
      checks++; if (IllegalCount !== '0) begin errors++; $display("FAIL illegal_count_before got %0d exp 0", IllegalCount); end
      drive_req(2'b10, 6'h03, 32'd0, 32'd0, 4'hC, ok);
      recv_rsp(got, r, e);
      checks++; if (!ok || !got) begin errors++; $display("FAIL illegal_handshake acc %b rsp %b exp 1 1", ok, got); end
      checks++; if (r.illegal !== 1'b1 || r.result !== '0 || r.zero !== 1'b0) begin
         errors++; $display("FAIL illegal_rsp got i%b r%h z%b exp i1 r0 z0", r.illegal, r.result, r.zero); end
      checks++; if (IllegalCount !== 4'd1) begin errors++; $display("FAIL illegal_count got %0d exp 1", IllegalCount); end
      drive_req(2'b11, 6'h20, 32'd7, 32'd9, 4'hD, ok);
      recv_rsp(got, r, e);
      checks++; if (r.illegal !== e.illegal || r.result !== e.result || r.zero !== e.zero || r.tag !== 4'hD) begin
         errors++; $display("FAIL illegal_ext_rsp got i%b r%h z%b t%h exp i%b r%h z%b tD", r.illegal, r.result, r.zero, r.tag, e.illegal, e.result, e.zero); end
      checks++; if (IllegalCount !== exp_ill[CNT_W-1:0] || OpCount !== exp_ops[CNT_W-1:0]) begin
         errors++; $display("FAIL illegal_counts got %0d/%0d exp %0d/%0d", IllegalCount, OpCount, exp_ill, exp_ops); end
   endtask

   task automatic test_reset_exec();
      bit ok;
      int seen;
      drive_req(2'b00, 6'h00, 32'd1, 32'd2, 4'h5, ok);
      checks++; if (!ok || ALUControl !== 3'd2) begin errors++; $display("FAIL rexec_setup acc %b aluctl %0d exp 1 2", ok, ALUControl); end
      #2 Rst_n = 1'b0;
      #1;
      checks++; if (bus.RspValid !== 1'b0 || ALUControl !== '0 || A !== '0) begin
         errors++; $display("FAIL rexec_async got v%b c%0d a%h exp 0", bus.RspValid, ALUControl, A); end
      checks++; if (OpCount !== '0 || IllegalCount !== '0) begin errors++; $display("FAIL rexec_counters got %0d/%0d exp 0/0", OpCount, IllegalCount); end
      sb.delete();
      exp_ops = 0;
      exp_ill = 0;
      @(posedge Clk); #1;
      Rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         if (bus.RspValid !== 1'b0) seen++;
         @(posedge Clk); #1;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL rexec_no_rsp got %0d valid cycles exp 0", seen); end
   endtask

   task automatic test_back_to_back();
      bit ok, got;
      rsp_t r, e1, e2;
      int bad;
      drive_req(2'b10, 6'h20, 32'd100, 32'd23, 4'hA, ok);
      @(posedge Clk); #1;
      checks++; if (!ok || bus.RspValid !== 1'b1 || sb.size() != 1) begin errors++; $display("FAIL b2b_first acc %b valid %b exp 1 1", ok, bus.RspValid); end
      e1 = sb.pop_front();
      bus.ReqValid = 1'b1; bus.ReqALUOp = 2'b10; bus.ReqFunct = 6'h22;
      bus.ReqA = 32'd50; bus.ReqB = 32'd8; bus.ReqTag = 4'hB;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         if (bus.RspValid !== 1'b1 || bus.RspResult !== e1.result || bus.RspTag !== e1.tag ||
             bus.RspZero !== e1.zero || bus.ReqReady !== 1'b0) bad++;
         @(posedge Clk); #1;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL b2b_hold got %0d unstable cycles exp 0", bad); end
      checks++; if (e1.result !== 32'd123) begin errors++; $display("FAIL b2b_model got %h exp 7b", e1.result); end
      checks++; if (A !== 32'd100 || OpCount !== '0) begin errors++; $display("FAIL b2b_no_sample got A=%h cnt=%0d exp 64 0", A, OpCount); end
      @(negedge Clk);
      bus.RspReady = 1'b1;
      #1;
      checks++; if (bus.ReqReady !== 1'b1) begin errors++; $display("FAIL b2b_comb_ready got %b exp 1", bus.ReqReady); end
      @(posedge Clk); #1;
      bus.RspReady = 1'b0;
      bus.ReqValid = 1'b0;
      sb.push_back(model(2'b10, 6'h22, 32'd50, 32'd8, 4'hB));
      exp_ops = sat_inc(exp_ops);
      checks++; if (OpCount !== exp_ops[CNT_W-1:0]) begin errors++; $display("FAIL b2b_opcount1 got %0d exp %0d", OpCount, exp_ops); end
      checks++; if (bus.RspValid !== 1'b0 || A !== 32'd50 || ALUControl !== 3'd6) begin
         errors++; $display("FAIL b2b_accept got v%b A=%h c%0d exp 0 32 6", bus.RspValid, A, ALUControl); end
      @(posedge Clk); #1;
      checks++; if (bus.RspValid !== 1'b1) begin errors++; $display("FAIL b2b_latency got %b exp 1", bus.RspValid); end
      recv_rsp(got, r, e2);
      checks++; if (!got || r.result !== 32'd42 || r.result !== e2.result || r.tag !== 4'hB) begin
         errors++; $display("FAIL b2b_second got %h tag %h exp 2a tag b", r.result, r.tag); end
      checks++; if (OpCount !== exp_ops[CNT_W-1:0]) begin errors++; $display("FAIL b2b_opcount2 got %0d exp %0d", OpCount, exp_ops); end
   endtask

   task automatic test_saturation();
      logic [1:0] l_op [9] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11};
      logic [5:0] l_fn [9] = '{6'h00, 6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h24, 6'h25};
      bit ok, got;
      rsp_t r, e;
      int k;
      logic [1:0]  op;
      logic [5:0]  fn;
      logic [31:0] a, b;
      for (int i = 0; i < 20; i++) begin
         k = $urandom_range(0, 8);
         op = l_op[k];
         fn = l_fn[k];
         if (i % 5 == 4) begin op = 2'b10; fn = 6'h3F; end
         a = $urandom();
         b = (i % 3 == 0) ? a : $urandom();
         drive_req(op, fn, a, b, TAG_W'(i), ok);
         recv_rsp(got, r, e);
         checks++; if (!ok || !got) begin errors++; $display("FAIL sat_handshake[%0d] acc %b rsp %b exp 1 1", i, ok, got); end
         checks++; if (r.result !== e.result || r.zero !== e.zero || r.illegal !== e.illegal || r.tag !== e.tag) begin
            errors++; $display("FAIL sat_rsp[%0d] got %h z%b i%b t%h exp %h z%b i%b t%h", i, r.result, r.zero, r.illegal, r.tag, e.result, e.zero, e.illegal, e.tag); end
         checks++; if (OpCount !== exp_ops[CNT_W-1:0]) begin errors++; $display("FAIL sat_opcount[%0d] got %0d exp %0d", i, OpCount, exp_ops); end
      end
      checks++; if (OpCount !== 4'd15) begin errors++; $display("FAIL sat_final_opcount got %0d exp 15", OpCount); end
      checks++; if (IllegalCount !== 4'd4) begin errors++; $display("FAIL sat_final_illcount got %0d exp 4", IllegalCount); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_ops();
      test_illegal();
      test_reset_exec();
      test_back_to_back();
      test_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Initiator side of the ALU32Bit interface. Accepts operation requests (ALUOp, Funct, operands, tag) on a valid/ready handshake.
- Decodes each request to a 3-bit ALUControl code and drives registered A/B/ALUControl into the ALU.
- Captures ALUResult/Zero and returns them on a valid/ready response channel.
- Keeps saturating completed-op and illegal-op counters for debug.

Parameters:
- TAG_W, 4, width of request/response tag
- CNT_W, 16, width of OpCount and IllegalCount

Ports:
- Clk  in  1  clock, rising edge
- Rst_n  in  1  reset, asynchronous assert, active-low
- ReqValid  in  1  request valid
- ReqReady  out  1  request accepted when ReqValid&ReqReady
- ReqALUOp  in  2  00 add, 01 sub, 10 R-type via Funct, 11 extended via Funct
- ReqFunct  in  6  function field
- ReqA  in  32  operand A
- ReqB  in  32  operand B
- ReqTag  in  TAG_W  tag returned with response
- ALUControl  out  3  to ALU, registered
- A  out  32  to ALU, registered
- B  out  32  to ALU, registered
- ALUResult  in  32  from ALU, combinational from A/B/ALUControl
- Zero  in  1  from ALU
- RspValid  out  1  response valid
- RspReady  in  1  response consumed when RspValid&RspReady
- RspResult  out  32  captured result
- RspZero  out  1  captured Zero
- RspIllegal  out  1  request was undecodable
- RspTag  out  TAG_W  tag of request
- OpCount  out  CNT_W  responses completed, saturating
- IllegalCount  out  CNT_W  illegal responses completed, saturating

Behaviour:
- Reset (Rst_n low, asynchronous): state IDLE, all registered outputs 0, counters 0, RspValid 0. An in-flight op or held response is discarded. There is no output after reset until a new request is accepted.
- Decode:
  - ALUOp 00 -> 2 (add); ALUOp 01 -> 6 (sub).
  - ALUOp 10, Funct 0x20 -> 2, 0x22 -> 6, 0x24 -> 0, 0x25 -> 1, 0x2A -> 7.
  - ALUOp 11, Funct 0x24 -> 4 (A&~B), 0x25 -> 5 (A|~B).
  - Any other combination is illegal.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: ReqReady=1. On accept, register A, B, decoded ALUControl, tag and illegal flag; go to EXEC.
  - EXEC: ALU inputs are stable. At the end of the cycle capture ALUResult and Zero into the Rsp* registers. If illegal, force RspResult=0, RspZero=0, RspIllegal=1. Go to RESP.
  - RESP: RspValid=1. Rsp* outputs are held stable until RspReady.
    - On RspReady without an accept, go to IDLE.
    - ReqReady = RspReady in RESP, combinational path. If ReqValid is also high, the new request is accepted in the same cycle: go directly to EXEC, and the new operands are registered on that edge.
- Latency and throughput:
  - Accept at edge N. A/B/ALUControl are valid after N. RspValid rises after edge N+1.
  - Peak throughput is 1 op per 2 cycles.
- A, B and ALUControl keep their last values in IDLE; they are not zeroed.
- OpCount increments on each response handshake. IllegalCount increments on handshakes with RspIllegal=1. Both saturate at all-ones, with no wrap.
- ReqValid while not ready: nothing is sampled. The requester must hold its inputs.
- Illegal ops still complete a full EXEC/RESP cycle so that tag ordering is preserved.

Decomposition:
- Package alu_issue_pkg holds:
  - ALUControl encodings: AND=0, OR=1, ADD=2, ANDN=4, ORN=5, SUB=6, SLT=7.
  - Funct constants: 0x20, 0x22, 0x24, 0x25, 0x2A.
  - ALUOp encodings.
  - FSM state enum.
- One combinational sub-module, alu_funct_decode: inputs ALUOp and Funct; outputs ALUControl[2:0] and Illegal. The top-level holds the FSM, registers and counters, and is bench-connected to a real ALU32Bit instance.

Test Plan:
- Reset with ALUOp=10, Funct=0x20, A=5, B=7, tag 3 -> ALUControl=2 one cycle after accept; RspValid two edges after accept; RspResult=12, RspZero=0, RspTag=3.
- ALUOp=01, A=B=0x1234 -> RspResult=0, RspZero=1. ALUOp=10, Funct=0x2A, A=3, B=9 -> RspResult=1.
- ALUOp=11, Funct=0x24, A=0xFF, B=0x0F -> RspResult=0xF0. ALUOp=10, Funct=0x03 -> RspIllegal=1, RspResult=0, IllegalCount 0->1.
- Hold RspReady=0 for 5 cycles, then pulse it with ReqValid=1 -> Rsp* stable throughout; new request accepted on the RspReady cycle; next RspValid 2 edges later; OpCount +1 per handshake.
- Assert Rst_n low during EXEC -> RspValid, counters and ALUControl go to 0 immediately without a clock edge; no response appears after release.
- Preload OpCount near saturation (CNT_W=4 build) and run 20 ops -> OpCount stops at 15.
